// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter that shares one i2c_master register-write engine between NREQ clients,
// sequencing start/ready for one transaction and answering the winner with ack or err.
module i2c_write_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_dev_id,
   input  logic [8*NREQ-1:0] req_reg_id,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   err,
   output logic              busy,
   output logic [2:0]        grant_id,
   output logic              i2c_start,
   output logic [7:0]        i2c_dev_id,
   output logic [7:0]        i2c_reg_id,
   output logic [7:0]        i2c_data,
   input  logic              i2c_ready
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      ptr, ptr_nxt;
   logic [2:0]      grant_nxt;
   logic            start_nxt;
   logic            err_flag, err_flag_nxt;
   logic            load;
   logic            timed_out;
   logic            found;
   logic [2:0]      winner;
   logic [3:0]      slot;
   logic [7:0]      sel_dev, sel_reg, sel_data;
   logic [NREQ-1:0] gnt_oh;

   // Search upward from ptr with wrap; first asserted request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      slot   = '0;
      for (int off = 0; off < NREQ; off++) begin
         slot = {1'b0, ptr} + 4'(off);
         if (slot >= 4'(NREQ)) slot = slot - 4'(NREQ);
         for (int i = 0; i < NREQ; i++)
            if (!found && slot == 4'(i) && req[i]) begin
               found  = 1'b1;
               winner = 3'(i);
            end
      end
   end

   always_comb begin
      sel_dev  = '0;
      sel_reg  = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (winner == 3'(i)) begin
            sel_dev  = req_dev_id[8*i +: 8];
            sel_reg  = req_reg_id[8*i +: 8];
            sel_data = req_data[8*i +: 8];
         end
   end

   assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      ptr_nxt      = ptr;
      grant_nxt    = grant_id;
      start_nxt    = i2c_start;
      err_flag_nxt = err_flag;
      load         = 1'b0;
      timed_out    = (cnt == TMAX);
      case (state)
         IDLE: begin
            if (i2c_ready && found) begin
               load         = 1'b1;
               grant_nxt    = winner;
               start_nxt    = 1'b1;
               cnt_nxt      = '0;
               err_flag_nxt = 1'b0;
               state_nxt    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!i2c_ready) begin
               start_nxt = 1'b0;
               cnt_nxt   = '0;
               state_nxt = WAIT_DONE;
            end else if (timed_out) begin
               start_nxt    = 1'b0;
               err_flag_nxt = 1'b1;
               state_nxt    = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (i2c_ready) begin
               err_flag_nxt = 1'b0;
               state_nxt    = DONE;
            end else if (timed_out) begin
               err_flag_nxt = 1'b1;
               state_nxt    = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            // No arbitration here: gives the requester a cycle to drop req.
            ptr_nxt   = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         ptr        <= '0;
         grant_id   <= '0;
         i2c_start  <= 1'b0;
         i2c_dev_id <= '0;
         i2c_reg_id <= '0;
         i2c_data   <= '0;
         err_flag   <= 1'b0;
         ack        <= '0;
         err        <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ptr       <= ptr_nxt;
         grant_id  <= grant_nxt;
         i2c_start <= start_nxt;
         err_flag  <= err_flag_nxt;
         if (load) begin
            i2c_dev_id <= sel_dev;
            i2c_reg_id <= sel_reg;
            i2c_data   <= sel_data;
         end
         ack <= '0;
         err <= '0;
         if (state != DONE && state_nxt == DONE) begin
            if (err_flag_nxt) err <= gnt_oh;
            else              ack <= gnt_oh;
         end
      end
   end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter: table of arbitration vectors against a behavioural
// i2c master, plus hand sequences for timeouts, held requests and asynchronous reset.
module tb_i2c_write_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;

   logic              clk;
   logic              reset_n;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_dev_id, req_reg_id, req_data;
   logic [NREQ-1:0]   ack, err;
   logic              busy;
   logic [2:0]        grant_id;
   logic              i2c_start;
   logic [7:0]        i2c_dev_id, i2c_reg_id, i2c_data;
   logic              i2c_ready;

   int errors = 0;
   int checks = 0;
   bit mmode;        // 0: normal master, 1: ready forced high
   int lat;          // cycles the master keeps ready low per transaction

   i2c_write_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .req(req),
      .req_dev_id(req_dev_id), .req_reg_id(req_reg_id), .req_data(req_data),
      .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
      .i2c_start(i2c_start), .i2c_dev_id(i2c_dev_id), .i2c_reg_id(i2c_reg_id),
      .i2c_data(i2c_data), .i2c_ready(i2c_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Master: on a sampled start it drops ready for lat cycles, then raises it.
   initial begin
      bit s;
      int mcnt;
      i2c_ready = 1'b1;
      mcnt      = 0;
      forever begin
         @(negedge clk);
         s = i2c_start;
         @(posedge clk);
         #1;
         if (mmode) begin
            i2c_ready = 1'b1;
            mcnt      = 0;
         end else if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 0) i2c_ready = 1'b1;
         end else if (s && i2c_ready) begin
            i2c_ready = 1'b0;
            mcnt      = lat;
         end else begin
            i2c_ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [7:0] dev_of(input int i);
      return 8'h4F + 8'(i);
   endfunction
   function automatic logic [7:0] reg_of(input int i);
      return 8'h0F + 8'(i);
   endfunction
   function automatic logic [7:0] data_of(input int i);
      return 8'hA9 + 8'(i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Waits for an ack/err pulse, records it, drops the answered req bits like a client would.
   task automatic wait_done(input int budget, output logic [3:0] a, output logic [3:0] e,
                            output int g, output logic [23:0] trip, output int stc,
                            output logic [3:0] extra, output bit to);
      a = '0; e = '0; g = -1; trip = '0; stc = 0; extra = '0; to = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (i2c_start) stc++;
         if ((ack | err) != '0) begin
            a    = ack;
            e    = err;
            g    = int'(grant_id);
            trip = {i2c_dev_id, i2c_reg_id, i2c_data};
            req  = req & ~(ack | err);
            @(negedge clk);
            extra = ack | err;
            to    = 1'b0;
            break;
         end
      end
   endtask

   typedef struct {
      logic [3:0] req_add;
      int         gnt;
   } vec_t;

   initial begin
      vec_t        vecs [15];
      logic [3:0]  a, e, extra;
      logic [23:0] trip;
      int          g, stc, acks, rises, errs, viol;
      bit          to, prev, seen;

      vecs[0]  = '{4'b1111, 0};
      vecs[1]  = '{4'b0000, 1};
      vecs[2]  = '{4'b0000, 2};
      vecs[3]  = '{4'b0000, 3};
      vecs[4]  = '{4'b0010, 1};
      vecs[5]  = '{4'b1111, 2};
      vecs[6]  = '{4'b0000, 3};
      vecs[7]  = '{4'b0000, 0};
      vecs[8]  = '{4'b0000, 1};
      vecs[9]  = '{4'b1001, 3};
      vecs[10] = '{4'b0000, 0};
      vecs[11] = '{4'b1000, 3};
      vecs[12] = '{4'b1000, 3};
      vecs[13] = '{4'b0101, 0};
      vecs[14] = '{4'b0000, 2};

      reset_n = 1'b0;
      req     = '0;
      mmode   = 1'b0;
      lat     = 6;
      for (int i = 0; i < NREQ; i++) begin
         req_dev_id[8*i +: 8] = dev_of(i);
         req_reg_id[8*i +: 8] = reg_of(i);
         req_data[8*i +: 8]   = data_of(i);
      end

      repeat (3) @(negedge clk);
      check("reset_start", 32'(i2c_start), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_ack_err", 32'({ack, err}), 0);
      check("reset_grant", 32'(grant_id), 0);
      check("reset_triple", 32'({i2c_dev_id, i2c_reg_id, i2c_data}), 0);
      reset_n = 1'b1;

      for (int v = 0; v < 15; v++) begin
         req = req | vecs[v].req_add;
         wait_done(100, a, e, g, trip, stc, extra, to);
         check($sformatf("v%0d_complete", v), 32'(to), 0);
         check($sformatf("v%0d_grant", v), 32'(g), 32'(vecs[v].gnt));
         check($sformatf("v%0d_ack", v), 32'(a), 32'(1) << vecs[v].gnt);
         check($sformatf("v%0d_err", v), 32'(e), 0);
         check($sformatf("v%0d_triple", v), 32'(trip),
               32'({dev_of(vecs[v].gnt), reg_of(vecs[v].gnt), data_of(vecs[v].gnt)}));
         check($sformatf("v%0d_pulse_width", v), 32'(extra), 0);
         check($sformatf("v%0d_start_cycles", v), 32'(stc), 2);
      end

      // Requester 3 holds req continuously: one ack per launched transaction.
      req = 4'b1000; acks = 0; rises = 0; errs = 0; prev = i2c_start;
      for (int c = 0; c < 100; c++) begin
         if (c == 60) req = 4'b0000;
         @(negedge clk);
         if (ack[3]) acks++;
         if (err != '0) errs++;
         if (i2c_start && !prev) rises++;
         prev = i2c_start;
      end
      check("held_idle", 32'(busy), 0);
      check("held_ack_per_txn", 32'(acks), 32'(rises));
      check("held_several_txn", 32'(acks >= 4), 1);
      check("held_no_err", 32'(errs), 0);

      // Ready stuck high: start held TIMEOUT+1 cycles, then err.
      mmode = 1'b1;
      req   = 4'b0001;
      wait_done(100, a, e, g, trip, stc, extra, to);
      check("tbusy_complete", 32'(to), 0);
      check("tbusy_grant", 32'(g), 0);
      check("tbusy_err", 32'(e), 32'b0001);
      check("tbusy_ack", 32'(a), 0);
      check("tbusy_start_cycles", 32'(stc), TIMEOUT + 1);
      check("tbusy_pulse_width", 32'(extra), 0);
      check("tbusy_idle", 32'(busy), 0);
      mmode = 1'b0;

      // Master never finishes: err from WAIT_DONE, no grant while ready stays low.
      lat = 1000;
      req = 4'b0100;
      wait_done(100, a, e, g, trip, stc, extra, to);
      check("tdone_complete", 32'(to), 0);
      check("tdone_grant", 32'(g), 2);
      check("tdone_err", 32'(e), 32'b0100);
      check("tdone_ack", 32'(a), 0);
      req = req | 4'b0010;
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (i2c_start || busy) viol++;
      end
      check("tdone_no_grant_while_not_ready", 32'(viol), 0);
      mmode = 1'b1;
      @(negedge clk);
      check("tdone_no_early_grant", 32'(i2c_start), 0);
      @(negedge clk);
      check("tdone_grant_after_ready", 32'(i2c_start), 1);
      check("tdone_grant_id_after_ready", 32'(grant_id), 1);
      mmode = 1'b0;
      lat   = 6;
      wait_done(100, a, e, g, trip, stc, extra, to);
      check("tdone_next_complete", 32'(to), 0);
      check("tdone_next_ack", 32'(a), 32'b0010);
      check("tdone_next_err", 32'(e), 0);

      // Leaves ptr at 3 so a stale pointer would favour requester 3 below.
      req = 4'b0100;
      wait_done(100, a, e, g, trip, stc, extra, to);
      check("prerst_ack", 32'(a), 32'b0100);

      // Asynchronous reset while waiting for the master to finish.
      req  = 4'b0001;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = i2c_start;
      end
      for (int c = 0; c < 20 && seen; c++) begin
         @(negedge clk);
         seen = i2c_start;
      end
      check("rst_reached_wait_done", 32'({seen, busy}), 32'b01);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_start", 32'(i2c_start), 0);
      check("rst_async_busy", 32'(busy), 0);
      check("rst_async_ack_err", 32'({ack, err}), 0);
      req   = '0;
      mmode = 1'b1;
      @(negedge clk);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_triple", 32'({i2c_dev_id, i2c_reg_id, i2c_data}), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      mmode   = 1'b0;
      req     = 4'b1100;
      wait_done(100, a, e, g, trip, stc, extra, to);
      check("rst_first_complete", 32'(to), 0);
      check("rst_first_grant", 32'(g), 2);
      check("rst_first_ack", 32'(a), 32'b0100);
      req = '0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
